// File: rtl/cov_serializer.sv
// rtl/cov_serializer.sv - captures an N x N covariance matrix and streams it out entry by entry
module cov_serializer #(
  parameter int N_STOCKS   = 2,
  parameter int WIDTH      = 16,
  parameter bit UPPER_ONLY = 1'b1,
  localparam int IDXW      = ($clog2(N_STOCKS) > 1) ? $clog2(N_STOCKS) : 1
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic                                         valid_in,
  input  logic [N_STOCKS-1:0][N_STOCKS-1:0][WIDTH-1:0] cov_in,
  output logic                                         ready_out,
  output logic                                         valid_out,
  input  logic                                         ready_in,
  output logic signed [WIDTH-1:0]                      data_out,
  output logic [IDXW-1:0]                              row_out,
  output logic [IDXW-1:0]                              col_out,
  output logic                                         last_out,
  output logic [7:0]                                   drop_count
);

  typedef enum logic {IDLE, SEND} state_t;

  localparam logic [IDXW-1:0] MAX_IDX = IDXW'(N_STOCKS - 1);

  state_t                                       state;
  logic [N_STOCKS-1:0][N_STOCKS-1:0][WIDTH-1:0] mat;
  logic [IDXW-1:0]                              nxt_row;
  logic [IDXW-1:0]                              nxt_col;
  logic                                         nxt_last;

  // Handshake flags decode straight from the state register, so no input reaches them
  assign ready_out = (state == IDLE);
  assign valid_out = (state == SEND);

  // Row-major successor of the entry currently presented; upper mode restarts each row on the diagonal
  always_comb begin
    nxt_row = row_out;
    nxt_col = col_out + IDXW'(1);
    if (col_out == MAX_IDX) begin
      nxt_row = row_out + IDXW'(1);
      nxt_col = UPPER_ONLY ? (row_out + IDXW'(1)) : '0;
    end
    nxt_last = (nxt_row == MAX_IDX) && (nxt_col == MAX_IDX);
  end

  // Capture/stream FSM with registered entry outputs and saturating drop counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      data_out   <= '0;
      row_out    <= '0;
      col_out    <= '0;
      last_out   <= 1'b0;
      drop_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (valid_in) begin
            mat      <= cov_in;
            data_out <= cov_in[0][0];
            row_out  <= '0;
            col_out  <= '0;
            last_out <= 1'b0;
            state    <= SEND;
          end
        end
        SEND: begin
          if (valid_in && (drop_count != 8'hFF)) begin
            drop_count <= drop_count + 8'd1;
          end
          if (ready_in) begin
            if (last_out) begin
              last_out <= 1'b0;
              state    <= IDLE;
            end else begin
              row_out  <= nxt_row;
              col_out  <= nxt_col;
              data_out <= mat[nxt_row][nxt_col];
              last_out <= nxt_last;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cov_serializer.sv
// tb/tb_cov_serializer.sv - directed self-checking bench for cov_serializer
module tb_cov_serializer;

  logic clk;
  logic rst;

  // N=2, upper-triangle instance
  logic                    valid_in2;
  logic [1:0][1:0][15:0]   cov2;
  logic                    ready_out2;
  logic                    valid_out2;
  logic                    ready_in2;
  logic signed [15:0]      data2;
  logic [0:0]              row2;
  logic [0:0]              col2;
  logic                    last2;
  logic [7:0]              drop2;

  // N=3, full-matrix instance
  logic                    valid_in3;
  logic [2:0][2:0][15:0]   cov3;
  logic                    ready_out3;
  logic                    valid_out3;
  logic                    ready_in3;
  logic signed [15:0]      data3;
  logic [1:0]              row3;
  logic [1:0]              col3;
  logic                    last3;
  logic [7:0]              drop3;

  int checks;
  int errors;

  cov_serializer #(.N_STOCKS(2), .WIDTH(16), .UPPER_ONLY(1'b1)) u_dut2 (
    .clk        (clk),
    .rst        (rst),
    .valid_in   (valid_in2),
    .cov_in     (cov2),
    .ready_out  (ready_out2),
    .valid_out  (valid_out2),
    .ready_in   (ready_in2),
    .data_out   (data2),
    .row_out    (row2),
    .col_out    (col2),
    .last_out   (last2),
    .drop_count (drop2)
  );

  cov_serializer #(.N_STOCKS(3), .WIDTH(16), .UPPER_ONLY(1'b0)) u_dut3 (
    .clk        (clk),
    .rst        (rst),
    .valid_in   (valid_in3),
    .cov_in     (cov3),
    .ready_out  (ready_out3),
    .valid_out  (valid_out3),
    .ready_in   (ready_in3),
    .data_out   (data3),
    .row_out    (row3),
    .col_out    (col3),
    .last_out   (last3),
    .drop_count (drop3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // entry word = {row, col, last, data}
  function automatic logic [18:0] ent2(input logic r, input logic c, input logic l, input logic [15:0] d);
    return {r, c, l, d};
  endfunction

  initial begin
    int rdy [6];
    logic [18:0] exp_ent [3];
    int idx;
    int xfers;

    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    valid_in2 = 1'b0;
    ready_in2 = 1'b1;
    cov2      = '0;
    valid_in3 = 1'b0;
    ready_in3 = 1'b1;
    cov3      = '0;

    // reset, then reset coinciding with valid_in
    tick();
    cov2[0][0] = 16'd5;
    valid_in2  = 1'b1;
    tick();
    valid_in2  = 1'b0;
    chk("rst_ready_out", ready_out2, 1'b1);
    chk("rst_valid_out", valid_out2, 1'b0);
    chk("rst_entry", ent2(row2, col2, last2, data2), ent2(0, 0, 0, 16'd0));
    chk("rst_drop", drop2, 8'd0);
    chk("rst3_valid_out", valid_out3, 1'b0);
    rst = 1'b0;
    tick();
    chk("rst_valid_no_capture", valid_out2, 1'b0);

    // basic stream, N=2 upper, ready held high
    cov2[0][0] = 16'd1249; cov2[0][1] = 16'd527;
    cov2[1][0] = 16'd527;  cov2[1][1] = 16'd3853;
    valid_in2 = 1'b1;
    tick();
    valid_in2 = 1'b0;
    chk("basic_valid0", valid_out2, 1'b1);
    chk("basic_ready0", ready_out2, 1'b0);
    chk("basic_e0", ent2(row2, col2, last2, data2), ent2(0, 0, 0, 16'd1249));
    tick();
    chk("basic_e1", ent2(row2, col2, last2, data2), ent2(0, 1, 0, 16'd527));
    tick();
    chk("basic_e2", ent2(row2, col2, last2, data2), ent2(1, 1, 1, 16'd3853));
    chk("basic_valid2", valid_out2, 1'b1);
    tick();
    chk("basic_done_valid", valid_out2, 1'b0);
    chk("basic_done_ready", ready_out2, 1'b1);

    // backpressure: ready_in 1,0,0,1,0,1
    rdy[0] = 1; rdy[1] = 0; rdy[2] = 0; rdy[3] = 1; rdy[4] = 0; rdy[5] = 1;
    exp_ent[0] = ent2(0, 0, 0, 16'd1249);
    exp_ent[1] = ent2(0, 1, 0, 16'd527);
    exp_ent[2] = ent2(1, 1, 1, 16'd3853);
    idx   = 0;
    xfers = 0;
    valid_in2 = 1'b1;
    tick();
    valid_in2 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      ready_in2 = (rdy[i] != 0);
      chk($sformatf("stall_step%0d", i), {valid_out2, ent2(row2, col2, last2, data2)}, {1'b1, exp_ent[idx]});
      if (valid_out2 && ready_in2) xfers++;
      if (rdy[i] != 0) idx++;
      tick();
    end
    chk("stall_xfers", xfers, 3);
    chk("stall_done_valid", valid_out2, 1'b0);
    ready_in2 = 1'b1;

    // negative entry passes through bit-exact
    cov2[0][0] = 16'h0000; cov2[0][1] = 16'hFD00;
    cov2[1][0] = 16'hFD00; cov2[1][1] = 16'h0300;
    valid_in2 = 1'b1;
    tick();
    valid_in2 = 1'b0;
    chk("neg_e0", ent2(row2, col2, last2, data2), ent2(0, 0, 0, 16'h0000));
    tick();
    chk("neg_e1", ent2(row2, col2, last2, data2), ent2(0, 1, 0, 16'hFD00));
    chk("neg_sign", (data2 < 0), 1'b1);
    tick();
    chk("neg_e2", ent2(row2, col2, last2, data2), ent2(1, 1, 1, 16'h0300));
    tick();

    // drops during SEND and cov_in changing mid-stream
    cov2[0][0] = 16'd11; cov2[0][1] = 16'd22;
    cov2[1][0] = 16'd22; cov2[1][1] = 16'd33;
    ready_in2 = 1'b0;
    valid_in2 = 1'b1;
    tick();
    cov2[0][0] = 16'd99; cov2[0][1] = 16'd98;
    cov2[1][0] = 16'd97; cov2[1][1] = 16'd96;
    tick();
    valid_in2 = 1'b0;
    tick();
    valid_in2 = 1'b1;
    tick();
    valid_in2 = 1'b0;
    chk("drop_two", drop2, 8'd2);
    chk("drop_hold_e0", ent2(row2, col2, last2, data2), ent2(0, 0, 0, 16'd11));
    ready_in2 = 1'b1;
    tick();
    chk("drop_e1", ent2(row2, col2, last2, data2), ent2(0, 1, 0, 16'd22));
    tick();
    chk("drop_e2", ent2(row2, col2, last2, data2), ent2(1, 1, 1, 16'd33));
    tick();
    chk("drop_done_valid", valid_out2, 1'b0);

    // saturation: 300 ignored pulses after a capture
    ready_in2 = 1'b0;
    valid_in2 = 1'b1;
    tick();
    repeat (300) tick();
    valid_in2 = 1'b0;
    chk("drop_saturate", drop2, 8'd255);
    ready_in2 = 1'b1;
    repeat (3) tick();
    chk("sat_done_valid", valid_out2, 1'b0);

    // N=3 full matrix, entries 1..9
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        cov3[r][c] = 16'(r * 3 + c + 1);
    valid_in3 = 1'b1;
    tick();
    valid_in3 = 1'b0;
    for (int i = 0; i < 9; i++) begin
      chk($sformatf("n3_e%0d", i), {valid_out3, row3, col3, last3, data3},
          {1'b1, 2'(i / 3), 2'(i % 3), (i == 8), 16'(i + 1)});
      tick();
    end
    chk("n3_done_valid", valid_out3, 1'b0);
    chk("n3_done_ready", ready_out3, 1'b1);

    // reset mid-stream after two transfers
    cov2[0][0] = 16'd1; cov2[0][1] = 16'd2;
    cov2[1][0] = 16'd2; cov2[1][1] = 16'd3;
    valid_in2 = 1'b1;
    tick();
    valid_in2 = 1'b0;
    tick();
    tick();
    chk("mid_pre_rst_e2", ent2(row2, col2, last2, data2), ent2(1, 1, 1, 16'd3));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_valid", valid_out2, 1'b0);
    chk("mid_rst_ready", ready_out2, 1'b1);
    chk("mid_rst_entry", ent2(row2, col2, last2, data2), ent2(0, 0, 0, 16'd0));
    chk("mid_rst_drop", drop2, 8'd0);
    cov2[0][0] = 16'd7; cov2[0][1] = 16'd8;
    valid_in2 = 1'b1;
    tick();
    valid_in2 = 1'b0;
    chk("restart_e0", {valid_out2, ent2(row2, col2, last2, data2)}, {1'b1, ent2(0, 0, 0, 16'd7)});
    tick();
    chk("restart_e1", ent2(row2, col2, last2, data2), ent2(0, 1, 0, 16'd8));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cov_serializer.md
# cov_serializer

Consumer for the covariance engine's matrix output. It captures one `N_STOCKS x N_STOCKS` signed 8.8 covariance matrix when `valid_in` is asserted. It then streams the matrix out one entry per transfer over a valid/ready handshake, tagged with row/column indices. It sits between the covariance block and the downstream portfolio/host-link logic, converting the wide parallel `cov_out` bus into a narrow backpressurable stream.

## Interface
- `N_STOCKS`, 2, matrix dimension (>= 2)
- `WIDTH`, 16, bits per entry (signed, 8.8 fixed point at default)
- `UPPER_ONLY`, 1, 1: emit only entries with row <= col; 0: emit all N*N entries
- `IDXW`, derived = max(1, $clog2(N_STOCKS)), index width (localparam)

Ports:
- `clk`  in  1  clock; all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `valid_in`  in  1  matrix on `cov_in` is valid this cycle
- `cov_in`  in  [N_STOCKS][N_STOCKS][WIDTH] signed  matrix, `cov_in[row][col]`
- `ready_out`  out  1  block is idle and will capture on `valid_in`
- `valid_out`  out  1  `data_out`/`row_out`/`col_out`/`last_out` valid
- `ready_in`  in  1  downstream accepts current entry
- `data_out`  out  WIDTH signed  current entry
- `row_out`  out  IDXW  row index of current entry
- `col_out`  out  IDXW  column index of current entry
- `last_out`  out  1  current entry is final entry of the matrix
- `drop_count`  out  8  count of `valid_in` pulses ignored while busy (saturating)

## Operation
- States: IDLE and SEND.
- IDLE: `ready_out`=1, `valid_out`=0. On `valid_in`=1, register the entire `cov_in` into a local matrix buffer, set row=col=0, and go to SEND.
- SEND: `valid_out`=1 and `data_out`=buffer[row][col]. A transfer occurs on an edge with `valid_out && ready_in`.
- Order is row-major.
  - UPPER_ONLY=1: (0,0),(0,1)...(0,N-1),(1,1),...,(N-1,N-1), for N(N+1)/2 entries. After col==N-1, the next entry is row+1, col=row+1.
  - UPPER_ONLY=0: all N*N entries. After col==N-1, the next entry is row+1, col=0.
- `last_out`=1 only while presenting (N-1,N-1). A transfer of the last entry returns the block to IDLE.
- While `valid_out`=1 and `ready_in`=0, `data_out`, `row_out`, `col_out` and `last_out` hold stable.
- The buffer is written only on capture. Changes on `cov_in` during SEND have no effect.
- `valid_in`=1 in SEND is ignored, and `drop_count` increments by 1, saturating at 255.
- Entries pass through bit-exact. No arithmetic and no sign change, so negative values are preserved.
- Reset values (after the first edge with `rst`=1):
  - state IDLE, `ready_out`=1, `valid_out`=0
  - `data_out`=0, `row_out`=0, `col_out`=0, `last_out`=0, `drop_count`=0
  - buffer contents don't-care
- Reset mid-SEND aborts the stream. The remaining entries are discarded, and `valid_out` is 0 in the cycle after the reset edge.

## Timing
- Capture edge k (IDLE, `valid_in`=1): `valid_out`=1 with entry (0,0) from cycle k+1.
- Throughput with `ready_in` held high: one entry per cycle, no bubbles. The full matrix takes N(N+1)/2 cycles (UPPER_ONLY=1) or N*N cycles.
- Last-entry transfer at edge m: in cycle m+1, `valid_out`=0 and `ready_out`=1. The earliest new capture is edge m+1.
- `valid_in` on edge m itself (still SEND) counts as a drop.
- `ready_out` is a function of registered state only. There is no combinational path from `valid_in` or `ready_in` to any output.
- `rst` and `valid_in` together: reset wins, nothing is captured, and `drop_count` stays 0.

## Test plan
- N=2, UPPER_ONLY=1, `ready_in`=1. Capture {{1249,527},{527,3853}}. Expected: three consecutive cycles (0,0,1249), (0,1,527), (1,1,3853), with `last_out` only on the third, then IDLE.
- Same matrix with `ready_in` toggling 1,0,0,1,0,1. Expected: each entry is held stable through its stall cycles, there are exactly 3 transfers, and none is duplicated or skipped.
- N=2, matrix {{0x0000,0xFD00},{0xFD00,0x0300}}. Expected: `data_out`=0xFD00 (−3.0) exactly at (0,1), with sign preserved.
- N=3, UPPER_ONLY=0, entries 1..9 row-major. Expected: nine transfers in order 1..9, with `last_out` on 9 at (2,2).
- Pulse `valid_in` on 2 cycles during SEND, and change `cov_in` mid-stream. Expected: `drop_count`=2, the output stream is the originally captured matrix, and 300 drops saturate at 255.
- Assert `rst` after the 2nd transfer. Expected: next cycle `valid_out`=0, `ready_out`=1, all outputs 0; a new capture restarts at (0,0).
